// File: rtl/ir_cfg_pkg.sv
// ir_cfg_pkg
// Shared types and constants for the IR-camera configuration sequencer.
//   ir_cfg_state_t : sequencer FSM states
//   FRAME_HEAD     : first byte of every command frame
//   FRAME_TAIL0/1  : two-byte trailer that closes a frame
//   max3()         : constant helper used to size the shared timer
package ir_cfg_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_BOOT,
      S_FETCH,
      S_SEND,
      S_WAIT_ACK,
      S_GAP,
      S_DONE,
      S_ERROR
   } ir_cfg_state_t;

   localparam logic [7:0] FRAME_HEAD  = 8'hAA;
   localparam logic [7:0] FRAME_TAIL0 = 8'hEB;
   // The closing byte of a frame is the same value as the opening byte.
   localparam logic [7:0] FRAME_TAIL1 = FRAME_HEAD;

   // Largest of three delays; the timer must be wide enough for all of them.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/ir_cfg_sequencer_if.sv
// ir_cfg_sequencer_if
// Bundles the sequencer's ROM, UART and status signals.
//   start     : 1-cycle pulse that begins a configuration run
//   rom_index : ROM address (combinational ROM, data valid same cycle)
//   rom_data  : ROM byte at rom_index
//   tx_data   : byte offered to the UART TX
//   tx_valid  : tx_data is valid
//   tx_ready  : UART accepts the byte when tx_valid & tx_ready
//   rx_valid  : 1-cycle pulse, camera response byte received
//   busy      : run in progress
//   done      : all frames acknowledged (sticky)
//   error     : retries exhausted or malformed table (sticky)
//   cmd_idx   : current/last frame index
// master = sequencer side, slave = ROM/UART/control side.
interface ir_cfg_sequencer_if;

   logic       start;
   logic [7:0] rom_index;
   logic [7:0] rom_data;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       rx_valid;
   logic       busy;
   logic       done;
   logic       error;
   logic [3:0] cmd_idx;

   modport master (
      input  start, rom_data, tx_ready, rx_valid,
      output rom_index, tx_data, tx_valid, busy, done, error, cmd_idx
   );

   modport slave (
      output start, rom_data, tx_ready, rx_valid,
      input  rom_index, tx_data, tx_valid, busy, done, error, cmd_idx
   );

endinterface

// File: rtl/ir_cfg_timer.sv
// ir_cfg_timer
// Loadable down-counter shared by the boot, gap and acknowledge waits.
//   clk    : clock
//   rst    : synchronous active-high reset
//   load   : load 'value' this cycle (first cycle of a timed state)
//   value  : load value, delay minus one
//   expire : final cycle of the timed interval
// Loading N-1 on the entry cycle makes expire fall on the N-th cycle
// of the state, so the owning state lasts exactly N cycles (N >= 2).
module ir_cfg_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] value,
   output logic             expire
);

   logic [WIDTH-1:0] count;

   // Count down to zero after a load and then rest there until the next load.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (count != '0) begin
         count <= count - WIDTH'(1);
      end
   end

   // The load cycle itself never expires, so a stale count cannot end a fresh wait.
   assign expire = !load && (count <= WIDTH'(1));

endmodule

// File: rtl/ir_cfg_sequencer.sv
// ir_cfg_sequencer
// Walks the camera config ROM (CDS-3 frame then Save frame), streams each
// byte to the UART TX, waits for a camera response after every frame and
// resends a frame on timeout.
//   clk : clock
//   rst : synchronous active-high reset
//   bus : ir_cfg_sequencer_if.master (start, ROM, UART TX/RX and status)
module ir_cfg_sequencer
   import ir_cfg_pkg::*;
#(
   parameter int NUM_BYTES   = 18,
   parameter int BOOT_DELAY  = 1000000,
   parameter int GAP_CYCLES  = 50000,
   parameter int ACK_TIMEOUT = 200000,
   parameter int MAX_RETRY   = 3
) (
   input logic                  clk,
   input logic                  rst,
   ir_cfg_sequencer_if.master   bus
);

   localparam int CW = $clog2(max3(BOOT_DELAY, GAP_CYCLES, ACK_TIMEOUT) + 1);
   localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   localparam logic [CW-1:0] BOOT_LOAD = CW'(BOOT_DELAY - 1);
   localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] ACK_LOAD  = CW'(ACK_TIMEOUT - 1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
   localparam logic [7:0]    LAST_IDX  = 8'(NUM_BYTES - 1);
   localparam logic [7:0]    END_IDX   = 8'(NUM_BYTES);

   ir_cfg_state_t state;

   logic [7:0]    rom_index;
   logic [7:0]    frame_start;
   logic [7:0]    prev_byte;
   logic          tail_seen;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          busy;
   logic          done;
   logic          error;
   logic [3:0]    cmd_idx;
   logic [RW-1:0] retry;
   logic          timer_load;
   logic [CW-1:0] timer_value;
   logic          timer_expire;

   ir_cfg_timer #(
      .WIDTH (CW)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (timer_load),
      .value  (timer_value),
      .expire (timer_expire)
   );

   // Main sequencer. Every timed state is entered with timer_load raised for
   // its first cycle. prev_byte is cleared whenever a frame (re)starts so a
   // trailer can never be matched across a frame boundary. An ack on the
   // same cycle as the timeout is checked first and therefore wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         rom_index   <= '0;
         frame_start <= '0;
         prev_byte   <= '0;
         tail_seen   <= 1'b0;
         tx_data     <= '0;
         tx_valid    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         cmd_idx     <= '0;
         retry       <= '0;
         timer_load  <= 1'b0;
         timer_value <= '0;
      end else begin
         timer_load <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (bus.start) begin
                  rom_index   <= '0;
                  frame_start <= '0;
                  cmd_idx     <= '0;
                  retry       <= '0;
                  done        <= 1'b0;
                  error       <= 1'b0;
                  busy        <= 1'b1;
                  timer_load  <= 1'b1;
                  timer_value <= BOOT_LOAD;
                  state       <= S_BOOT;
               end
            end

            S_BOOT: begin
               if (timer_expire) begin
                  prev_byte <= '0;
                  state     <= S_FETCH;
               end
            end

            S_FETCH: begin
               tx_data   <= bus.rom_data;
               tx_valid  <= 1'b1;
               tail_seen <= (prev_byte == FRAME_TAIL0) && (bus.rom_data == FRAME_TAIL1);
               prev_byte <= bus.rom_data;
               state     <= S_SEND;
            end

            S_SEND: begin
               if (bus.tx_ready) begin
                  tx_valid  <= 1'b0;
                  rom_index <= rom_index + 8'd1;
                  if (tail_seen) begin
                     timer_load  <= 1'b1;
                     timer_value <= ACK_LOAD;
                     state       <= S_WAIT_ACK;
                  end else if (rom_index == LAST_IDX) begin
                     error <= 1'b1;
                     busy  <= 1'b0;
                     state <= S_ERROR;
                  end else begin
                     state <= S_FETCH;
                  end
               end
            end

            S_WAIT_ACK: begin
               if (bus.rx_valid) begin
                  retry   <= '0;
                  cmd_idx <= cmd_idx + 4'd1;
                  if (rom_index == END_IDX) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= S_DONE;
                  end else begin
                     timer_load  <= 1'b1;
                     timer_value <= GAP_LOAD;
                     state       <= S_GAP;
                  end
               end else if (timer_expire) begin
                  if (retry < RETRY_MAX) begin
                     retry     <= retry + RW'(1);
                     rom_index <= frame_start;
                     prev_byte <= '0;
                     state     <= S_FETCH;
                  end else begin
                     error <= 1'b1;
                     busy  <= 1'b0;
                     state <= S_ERROR;
                  end
               end
            end

            S_GAP: begin
               if (timer_expire) begin
                  frame_start <= rom_index;
                  prev_byte   <= '0;
                  state       <= S_FETCH;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // All outputs come straight from registers.
   assign bus.rom_index = rom_index;
   assign bus.tx_data   = tx_data;
   assign bus.tx_valid  = tx_valid;
   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.error     = error;
   assign bus.cmd_idx   = cmd_idx;

endmodule

// File: tb/tb_ir_cfg_sequencer.sv
// tb_ir_cfg_sequencer
// Directed bench for ir_cfg_sequencer with short delays
// (BOOT_DELAY=10, GAP_CYCLES=5, ACK_TIMEOUT=20, MAX_RETRY=2).
// Drives a combinational ROM model, a UART TX ready line and camera acks.
module tb_ir_cfg_sequencer;

   localparam int NB = 18;

   localparam logic [7:0] ROM_TABLE [NB] = '{
      8'hAA, 8'h06, 8'h01, 8'h5D, 8'h02, 8'h05, 8'h40, 8'h55, 8'hEB, 8'hAA,
      8'hAA, 8'h04, 8'h01, 8'h7F, 8'h02, 8'h30, 8'hEB, 8'hAA
   };

   logic clk;
   logic rst;

   int checks;
   int errors;

   logic [7:0] txBytes [$];
   int         txEdges [$];
   logic [7:0] expBytes [$];

   ir_cfg_sequencer_if dut_if ();

   ir_cfg_sequencer #(
      .NUM_BYTES   (NB),
      .BOOT_DELAY  (10),
      .GAP_CYCLES  (5),
      .ACK_TIMEOUT (20),
      .MAX_RETRY   (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (dut_if)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational config ROM; addresses past the table read as zero.
   assign dut_if.rom_data = (dut_if.rom_index < 8'(NB)) ? ROM_TABLE[dut_if.rom_index[4:0]] : 8'h00;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic int edgeAt(input int i);
      if (i < txEdges.size()) return txEdges[i];
      return -1000;
   endfunction

   task automatic expectFrame(input int f);
      int lo;
      int hi;
      lo = (f == 0) ? 0 : 10;
      hi = (f == 0) ? 10 : NB;
      for (int i = lo; i < hi; i++) expBytes.push_back(ROM_TABLE[i]);
   endtask

   task automatic compareStream(input string tag);
      int n;
      checkOutput({tag, "_count"}, txBytes.size(), expBytes.size());
      n = (txBytes.size() < expBytes.size()) ? txBytes.size() : expBytes.size();
      for (int i = 0; i < n; i++)
         checkOutput($sformatf("%s_byte%0d", tag, i), 32'(txBytes[i]), 32'(expBytes[i]));
   endtask

   task automatic checkStatus(input string tag, input logic expDone, input logic expError, input logic [3:0] expCmd);
      checkOutput({tag, "_busy"}, 32'(dut_if.busy), 32'd0);
      checkOutput({tag, "_done"}, 32'(dut_if.done), 32'(expDone));
      checkOutput({tag, "_error"}, 32'(dut_if.error), 32'(expError));
      checkOutput({tag, "_cmd_idx"}, 32'(dut_if.cmd_idx), 32'(expCmd));
   endtask

   // Pulses start, then runs the DUT until it leaves busy with done/error set.
   // Loop iteration cyc sits on a negedge and drives the inputs for the next
   // posedge; a byte seen with tx_valid & tx_ready is accepted on that edge.
   // The n-th trailer is acked ackDelay edges later when ackMask[n] is set.
   task automatic applyStimulus(input bit randomReady, input logic [7:0] ackMask, input int ackDelay,
                                input int strayStartAt, input int budget);
      int         tailCount;
      int         ackAt;
      bit         prevEb;
      bit         holding;
      bit         finished;
      logic [7:0] heldData;
      txBytes.delete();
      txEdges.delete();
      tailCount = 0;
      ackAt     = -1;
      prevEb    = 1'b0;
      holding   = 1'b0;
      finished  = 1'b0;
      heldData  = 8'h00;
      @(negedge clk);
      dut_if.start = 1'b1;
      @(negedge clk);
      dut_if.start = 1'b0;
      for (int cyc = 0; cyc < budget && !finished; cyc++) begin
         if (holding) begin
            checkOutput("hold_valid", 32'(dut_if.tx_valid), 32'd1);
            checkOutput("hold_data", 32'(dut_if.tx_data), 32'(heldData));
         end
         dut_if.tx_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
         dut_if.rx_valid = (cyc == ackAt);
         dut_if.start    = (cyc == strayStartAt);
         holding  = dut_if.tx_valid && !dut_if.tx_ready;
         heldData = dut_if.tx_data;
         if (dut_if.tx_valid && dut_if.tx_ready) begin
            txBytes.push_back(dut_if.tx_data);
            txEdges.push_back(cyc);
            if (prevEb && dut_if.tx_data == 8'hAA) begin
               if (tailCount < 8 && ackMask[tailCount]) ackAt = cyc + ackDelay;
               tailCount++;
            end
            prevEb = (dut_if.tx_data == 8'hEB);
         end
         @(negedge clk);
         if (!dut_if.busy && (dut_if.done || dut_if.error)) finished = 1'b1;
      end
      dut_if.tx_ready = 1'b1;
      dut_if.rx_valid = 1'b0;
      dut_if.start    = 1'b0;
      checkOutput("run_finished", 32'(finished), 32'd1);
   endtask

   initial begin
      int  acc;
      bit  hit;
      checks          = 0;
      errors          = 0;
      rst             = 1'b1;
      dut_if.start    = 1'b0;
      dut_if.tx_ready = 1'b1;
      dut_if.rx_valid = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("rst_tx_valid", 32'(dut_if.tx_valid), 32'd0);
      checkOutput("rst_tx_data", 32'(dut_if.tx_data), 32'd0);
      checkOutput("rst_rom_index", 32'(dut_if.rom_index), 32'd0);
      checkStatus("rst", 1'b0, 1'b0, 4'd0);
      rst = 1'b0;

      // 1: full run, ready always high, ack 3 cycles after each trailer
      $display("[TB] step 1: nominal run");
      applyStimulus(1'b0, 8'hFF, 3, -1, 2000);
      expBytes.delete();
      expectFrame(0);
      expectFrame(1);
      compareStream("nominal");
      checkStatus("nominal", 1'b1, 1'b0, 4'd2);
      checkOutput("nominal_rom_index", 32'(dut_if.rom_index), 32'd18);
      checkOutput("nominal_first_latency", 32'(edgeAt(0)), 32'd11);
      checkOutput("nominal_byte_spacing", 32'(edgeAt(1) - edgeAt(0)), 32'd2);
      checkOutput("nominal_gap", 32'(edgeAt(10) - edgeAt(9)), 32'd10);

      // 2: random backpressure, same stream, data held while stalled
      $display("[TB] step 2: random tx_ready");
      applyStimulus(1'b1, 8'hFF, 3, -1, 3000);
      compareStream("backpressure");
      checkStatus("backpressure", 1'b1, 1'b0, 4'd2);

      // 3: first CDS-3 attempt unanswered, then acked
      $display("[TB] step 3: one retry");
      applyStimulus(1'b0, 8'b0000_0110, 3, -1, 2000);
      expBytes.delete();
      expectFrame(0);
      expectFrame(0);
      expectFrame(1);
      compareStream("retry");
      checkStatus("retry", 1'b1, 1'b0, 4'd2);
      checkOutput("retry_resend_delay", 32'(edgeAt(10) - edgeAt(9)), 32'd22);

      // 4: no responses at all -> three CDS-3 attempts then error
      $display("[TB] step 4: retries exhausted");
      applyStimulus(1'b0, 8'h00, 3, -1, 2000);
      expBytes.delete();
      expectFrame(0);
      expectFrame(0);
      expectFrame(0);
      compareStream("exhaust");
      checkStatus("exhaust", 1'b0, 1'b1, 4'd0);

      // 5: reset while byte 5 is on the bus, then a clean restart
      $display("[TB] step 5: mid-run reset");
      @(negedge clk);
      dut_if.start = 1'b1;
      @(negedge clk);
      dut_if.start = 1'b0;
      acc = 0;
      hit = 1'b0;
      for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
         if (dut_if.tx_valid) begin
            if (acc == 4) hit = 1'b1;
            else acc++;
         end
         if (!hit) @(negedge clk);
      end
      checkOutput("midrst_reached", 32'(hit), 32'd1);
      checkOutput("midrst_byte5", 32'(dut_if.tx_data), 32'h02);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midrst_tx_valid", 32'(dut_if.tx_valid), 32'd0);
      checkOutput("midrst_tx_data", 32'(dut_if.tx_data), 32'd0);
      checkOutput("midrst_rom_index", 32'(dut_if.rom_index), 32'd0);
      checkStatus("midrst", 1'b0, 1'b0, 4'd0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b0, 8'hFF, 3, -1, 2000);
      expBytes.delete();
      expectFrame(0);
      expectFrame(1);
      compareStream("restart");
      checkStatus("restart", 1'b1, 1'b0, 4'd2);

      // 6: stray start mid-frame, and ack landing on the timeout cycle
      $display("[TB] step 6: stray start, ack at timeout");
      applyStimulus(1'b0, 8'hFF, 20, 16, 2000);
      compareStream("edgeack");
      checkStatus("edgeack", 1'b1, 1'b0, 4'd2);
      checkOutput("edgeack_gap", 32'(edgeAt(10) - edgeAt(9)), 32'd27);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
